// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo sequencer and its PWM stage.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    HOLD   = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam int DW_DEF          = 19;
  localparam int FRAME_LIMIT_DEF = 500000;
  localparam int DUTY_MIN_DEF    = 12500;
  localparam int DUTY_MAX_DEF    = 65000;
  localparam int HOME_DUTY_DEF   = 65000;
  localparam int DUTY_R_DEF      = 53500;
  localparam int DUTY_V_DEF      = 47000;
  localparam int DUTY_A_DEF      = 40500;
  localparam int STEP_DEF        = 6500;
  localparam int HOLD_FRAMES_DEF = 50;

  function automatic int clamp_duty(input int d, input int lo, input int hi);
    if (d < lo) return lo;
    if (d > hi) return hi;
    return d;
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo pin generator: high while the shared frame counter is below the duty word.
module servo_pwm_gen #(
  parameter int DW = 19
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic [DW-1:0] count,
  input  logic [DW-1:0] duty,
  output logic          pwm_out
);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) pwm_out <= 1'b0;
    else        pwm_out <= (count < duty);
  end

endmodule

// File: rtl/servo_seq_ctrl.sv
// Priority sequencer for a hobby servo: grant one colour request, slew to its angle,
// hold, slew home. Define SERVO_SEQ_PWM_EN to build the on-chip PWM pin generator.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int FRAME_LIMIT = FRAME_LIMIT_DEF,
  parameter int DUTY_MIN    = DUTY_MIN_DEF,
  parameter int DUTY_MAX    = DUTY_MAX_DEF,
  parameter int HOME_DUTY   = HOME_DUTY_DEF,
  parameter int DUTY_R      = DUTY_R_DEF,
  parameter int DUTY_V      = DUTY_V_DEF,
  parameter int DUTY_A      = DUTY_A_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          req_r,
  input  logic          req_v,
  input  logic          req_a,
  output logic [2:0]    ack,
  output logic [DW-1:0] duty,
  output logic          frame_tick,
  output logic          busy,
  output logic          done,
  output logic          pwm_out
);

  localparam logic [DW-1:0] TGT_R    = DW'(clamp_duty(DUTY_R, DUTY_MIN, DUTY_MAX));
  localparam logic [DW-1:0] TGT_V    = DW'(clamp_duty(DUTY_V, DUTY_MIN, DUTY_MAX));
  localparam logic [DW-1:0] TGT_A    = DW'(clamp_duty(DUTY_A, DUTY_MIN, DUTY_MAX));
  localparam logic [DW-1:0] TGT_HOME = DW'(clamp_duty(HOME_DUTY, DUTY_MIN, DUTY_MAX));
  localparam logic [DW-1:0] LIM_M1   = DW'(FRAME_LIMIT - 1);
  localparam logic [DW-1:0] TICK_PRE = DW'(FRAME_LIMIT - 2);
  localparam logic [DW-1:0] STEP_U   = DW'(STEP);
  localparam logic signed [DW:0] STEP_S = $signed((DW+1)'(STEP));
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HLAST = HW'(HOLD_FRAMES - 1);

  logic [DW-1:0] count;
  state_t        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [2:0]    gnt, ack_c;
  logic [DW-1:0] gnt_tgt;
  logic          done_c;

  // Move by at most STEP toward tgt; the DW+1-bit signed difference cannot wrap.
  function automatic logic [DW-1:0] slew(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic signed [DW:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)       slew = cur + STEP_U;
    else if (diff < -STEP_S) slew = cur - STEP_U;
    else                     slew = tgt;
  endfunction

  // Frame counter; tick is registered so it is high exactly while count == FRAME_LIMIT-1.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      frame_tick <= 1'b0;
    end else begin
      count      <= (count == LIM_M1) ? '0 : count + DW'(1);
      frame_tick <= (count == TICK_PRE);
    end
  end

  always_comb begin
    gnt     = 3'b000;
    gnt_tgt = TGT_R;
    if (req_r) begin
      gnt = 3'b001; gnt_tgt = TGT_R;
    end else if (req_v) begin
      gnt = 3'b010; gnt_tgt = TGT_V;
    end else if (req_a) begin
      gnt = 3'b100; gnt_tgt = TGT_A;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= TGT_HOME;
      tgt_q   <= TGT_HOME;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    hcnt_d  = hcnt_q;
    ack_c   = 3'b000;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          ack_c   = gnt;
          tgt_d   = gnt_tgt;
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (frame_tick) begin
          duty_d = slew(duty_q, tgt_q);
          if (duty_d == tgt_q) begin
            hcnt_d  = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (hcnt_q == HLAST) begin
            done_c  = 1'b1;
            tgt_d   = TGT_HOME;
            state_d = RETURN;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end
      RETURN: begin
        // A new request wins over this frame's slew; duty continues from where it is.
        if (|gnt) begin
          ack_c   = gnt;
          tgt_d   = gnt_tgt;
          state_d = MOVE;
        end else if (frame_tick) begin
          duty_d = slew(duty_q, tgt_q);
          if (duty_d == TGT_HOME) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack  = rst_n ? ack_c : 3'b000;
  assign done = done_c;
  assign duty = duty_q;
  assign busy = (state_q != IDLE);

`ifdef SERVO_SEQ_PWM_EN
  servo_pwm_gen #(.DW(DW)) u_pwm (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .count   (count),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );
`else
  assign pwm_out = 1'b0;
`endif

endmodule
